// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU register snapshot debug port.
// Optional feature macro: REG_SNAPSHOT_CHECKSUM_EN (appends the CHK byte).
package cpu_dbg_pkg;

    typedef enum logic {
        StIdle,
        StSend
    } snap_state_e;

    // Frame byte positions
    localparam logic [3:0] IDX_HDR = 4'd0;
    localparam logic [3:0] IDX_PCH = 4'd1;
    localparam logic [3:0] IDX_PCL = 4'd2;
    localparam logic [3:0] IDX_A   = 4'd3;
    localparam logic [3:0] IDX_X   = 4'd4;
    localparam logic [3:0] IDX_Y   = 4'd5;
    localparam logic [3:0] IDX_S   = 4'd6;
    localparam logic [3:0] IDX_P   = 4'd7;
    localparam logic [3:0] IDX_CHK = 4'd8;

`ifdef REG_SNAPSHOT_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif

    localparam logic [3:0] IDX_LAST = 4'(FRAME_LEN - 1);

endpackage

// File: rtl/frame_byte_mux.sv
// Combinational frame byte selection from the frozen snapshot.
// Optional feature macro: REG_SNAPSHOT_CHECKSUM_EN (adds the CHK byte).
module frame_byte_mux
    import cpu_dbg_pkg::*;
(
    input  logic [7:0]  i_header,
    input  logic [15:0] i_pc,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_x,
    input  logic [7:0]  i_y,
    input  logic [7:0]  i_s,
    input  logic [7:0]  i_p,
    input  logic [3:0]  i_idx,
    output logic [7:0]  o_byte
);

`ifdef REG_SNAPSHOT_CHECKSUM_EN
    logic [7:0] w_chk;

    // Checksum covers PC through P; the header is excluded
    always_comb begin
        w_chk = i_pc[15:8] ^ i_pc[7:0] ^ i_a ^ i_x ^ i_y ^ i_s ^ i_p;
    end
`endif

    // Select the byte at the current frame index
    always_comb begin
        o_byte = 8'h00;
        unique case (i_idx)
            IDX_HDR: o_byte = i_header;
            IDX_PCH: o_byte = i_pc[15:8];
            IDX_PCL: o_byte = i_pc[7:0];
            IDX_A:   o_byte = i_a;
            IDX_X:   o_byte = i_x;
            IDX_Y:   o_byte = i_y;
            IDX_S:   o_byte = i_s;
            IDX_P:   o_byte = i_p;
`ifdef REG_SNAPSHOT_CHECKSUM_EN
            IDX_CHK: o_byte = w_chk;
`endif
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/reg_snapshot_reader.sv
// Read-only debug port: captures A/X/Y/S/P/PC on request and streams them
// as a byte frame over a valid/ready interface.
// Optional feature macro: REG_SNAPSHOT_CHECKSUM_EN (9-byte frame with CHK).
module reg_snapshot_reader
    import cpu_dbg_pkg::*;
#(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [7:0]  i_a_in,
    input  logic [7:0]  i_x_in,
    input  logic [7:0]  i_y_in,
    input  logic [7:0]  i_s_in,
    input  logic [7:0]  i_p_in,
    input  logic [15:0] i_pc_in,
    output logic [7:0]  o_byte_data,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_busy,
    output logic        o_frame_done
);

    snap_state_e r_state;
    snap_state_e w_state_d;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_d;
    logic        r_done;
    logic        w_done_d;
    logic        w_capture;
    logic [7:0]  w_mux_byte;

    logic [7:0]  r_a;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_s;
    logic [7:0]  r_p;
    logic [15:0] r_pc;

    // State, index and done-pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_idx   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_done  <= w_done_d;
        end
    end

    // Snapshot is taken once at the request edge and held for the whole frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a  <= 8'h00;
            r_x  <= 8'h00;
            r_y  <= 8'h00;
            r_s  <= 8'h00;
            r_p  <= 8'h00;
            r_pc <= 16'h0000;
        end else if (w_capture) begin
            r_a  <= i_a_in;
            r_x  <= i_x_in;
            r_y  <= i_y_in;
            r_s  <= i_s_in;
            r_p  <= i_p_in;
            r_pc <= i_pc_in;
        end
    end

    // Next-state, index advance and handshake outputs
    always_comb begin
        w_state_d    = r_state;
        w_idx_d      = r_idx;
        w_done_d     = 1'b0;
        w_capture    = 1'b0;
        o_byte_valid = 1'b0;
        o_busy       = 1'b0;
        o_byte_data  = 8'h00;
        unique case (r_state)
            StIdle: begin
                if (i_req) begin
                    w_state_d = StSend;
                    w_idx_d   = IDX_HDR;
                    w_capture = 1'b1;
                end
            end
            StSend: begin
                o_byte_valid = 1'b1;
                o_busy       = 1'b1;
                o_byte_data  = w_mux_byte;
                if (i_byte_ready) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end else begin
                        w_idx_d = r_idx + 4'd1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_frame_done = r_done;

    frame_byte_mux u_frame_byte_mux (
        .i_header (HEADER),
        .i_pc     (r_pc),
        .i_a      (r_a),
        .i_x      (r_x),
        .i_y      (r_y),
        .i_s      (r_s),
        .i_p      (r_p),
        .i_idx    (r_idx),
        .o_byte   (w_mux_byte)
    );

endmodule

// File: tb/tb_reg_snapshot_reader.sv
// Self-checking bench for reg_snapshot_reader: directed scenarios plus a
// randomized run, all checked against a frame-level reference model.
module tb_reg_snapshot_reader;

`ifdef REG_SNAPSHOT_CHECKSUM_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rdy;
    logic [7:0]  a, x, y, s, p;
    logic [15:0] pc;
    logic [7:0]  data;
    logic        valid;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    reg_snapshot_reader #(
        .HEADER (8'hA5)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_a_in       (a),
        .i_x_in       (x),
        .i_y_in       (y),
        .i_s_in       (s),
        .i_p_in       (p),
        .i_pc_in      (pc),
        .o_byte_data  (data),
        .o_byte_valid (valid),
        .i_byte_ready (rdy),
        .o_busy       (busy),
        .o_frame_done (done)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a captured frame and the position of the offered byte
    logic [7:0] m_frame [0:8];
    int         m_pos  = 0;
    bit         m_act  = 1'b0;
    bit         m_done = 1'b0;

    logic [7:0] q_obs [$];
    int         n_done = 0;

    logic [7:0] exp_basic [0:8] = '{8'hA5, 8'hC0, 8'h00, 8'h12, 8'h34, 8'h56, 8'hFD,
                                    8'h24, 8'h69};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic build_frame();
        logic [7:0] chk;
        m_frame[0] = 8'hA5;
        m_frame[1] = pc[15:8];
        m_frame[2] = pc[7:0];
        m_frame[3] = a;
        m_frame[4] = x;
        m_frame[5] = y;
        m_frame[6] = s;
        m_frame[7] = p;
        chk = 8'h00;
        for (int i = 1; i <= 7; i++) chk ^= m_frame[i];
        m_frame[8] = chk;
    endtask

    // One clock: record accepted byte, advance model, sample after the edge
    task automatic tick();
        logic [7:0] exp_data;
        if (!rst && valid && rdy) q_obs.push_back(data);
        if (rst) begin
            m_act  = 1'b0;
            m_done = 1'b0;
            m_pos  = 0;
        end else if (!m_act) begin
            m_done = 1'b0;
            if (req) begin
                build_frame();
                m_act = 1'b1;
                m_pos = 0;
            end
        end else begin
            m_done = 1'b0;
            if (rdy) begin
                m_pos++;
                if (m_pos == FLEN) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                    m_pos  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        exp_data = m_act ? m_frame[m_pos] : 8'h00;
        check_eq("byte_valid", 16'(valid), 16'(m_act));
        check_eq("busy", 16'(busy), 16'(m_act));
        check_eq("frame_done", 16'(done), 16'(m_done));
        check_eq("byte_data", 16'(data), 16'(exp_data));
        if (done) n_done++;
    endtask

    task automatic set_basic();
        pc = 16'hC000; a = 8'h12; x = 8'h34; y = 8'h56; s = 8'hFD; p = 8'h24;
    endtask

    task automatic start_obs();
        q_obs.delete();
        n_done = 0;
    endtask

    task automatic drain();
        req = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!m_act && !m_done) break;
            tick();
        end
        tick();
    endtask

    // Compare the accepted bytes with the hand-computed basic frame
    task automatic frame_literal(input string tag);
        check_eq({tag, "_len"}, 16'(q_obs.size()), 16'(FLEN));
        check_eq({tag, "_done_cnt"}, 16'(n_done), 16'd1);
        for (int i = 0; i < FLEN && i < q_obs.size(); i++)
            check_eq({tag, "_byte"}, 16'(q_obs[i]), 16'(exp_basic[i]));
    endtask

    initial begin
        int stall;
        rst = 1'b1; req = 1'b0; rdy = 1'b0;
        set_basic();
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic frame, ready held high
        start_obs();
        req = 1'b1; rdy = 1'b1;
        tick();
        drain();
        frame_literal("basic");

        // Backpressure while X is offered
        start_obs();
        stall = 0;
        req = 1'b1; rdy = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rdy = !(m_act && m_pos == 4 && stall < 3);
            if (!rdy) stall++;
            tick();
        end
        drain();
        frame_literal("backpressure");

        // Live input change after capture must not leak into the frame
        start_obs();
        req = 1'b1;
        tick();
        req = 1'b0;
        a = 8'hFF;
        drain();
        frame_literal("freeze");
        a = 8'h12;

        // Request during SEND is dropped
        start_obs();
        req = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            req = m_act && m_pos == 4;
            tick();
        end
        drain();
        frame_literal("req_in_send");

        // Reset mid-frame, then a clean frame
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_pos == 5) break;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_valid", 16'(valid), 16'd0);
        check_eq("rst_done", 16'(done), 16'd0);
        start_obs();
        req = 1'b1;
        tick();
        drain();
        frame_literal("after_reset");

        // Back-to-back with req held high
        req = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 3 * (FLEN + 2); i++) tick();
        drain();

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            req = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) begin
                a  = 8'($urandom);
                x  = 8'($urandom);
                y  = 8'($urandom);
                s  = 8'($urandom);
                p  = 8'($urandom);
                pc = 16'($urandom);
            end
            tick();
        end
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
